// File: rtl/shift_add_multiplier_if.sv
// shift_add_multiplier_if: start/operand/result handshake between a controller and the multiplier.
interface shift_add_multiplier_if #(
    parameter int N = 4
);
    logic           Start;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic [2*N-1:0] P;
    logic           Busy;
    logic           Done;
    modport master (output Start, A, B, input P, Busy, Done);
    modport slave (input Start, A, B, output P, Busy, Done);
endinterface

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned N x N shift-and-add multiplier, one partial product per clock.
module shift_add_multiplier #(
    parameter int N     = 4,
    parameter int CNT_W = 3
) (
    input logic                  Clk,
    input logic                  Rst,
    shift_add_multiplier_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t         state, state_next;
    logic [2*N-1:0] acc, acc_n, acc_sum, mcand, mcand_n, p_reg, p_n;
    logic [N-1:0]   mplier, mplier_n;
    logic [CNT_W-1:0] count, count_n;
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            p_reg  <= '0;
        end else begin
            state  <= state_next;
            acc    <= acc_n;
            mcand  <= mcand_n;
            mplier <= mplier_n;
            count  <= count_n;
            p_reg  <= p_n;
        end
    end
    always_comb begin
        acc_sum    = acc + (mplier[0] ? mcand : '0);
        state_next = state;
        acc_n      = acc;
        mcand_n    = mcand;
        mplier_n   = mplier;
        count_n    = count;
        p_n        = p_reg;
        case (state)
            IDLE: if (bus.Start) begin
                acc_n      = '0;
                mcand_n    = {{N{1'b0}}, bus.A};
                mplier_n   = bus.B;
                count_n    = '0;
                state_next = CALC;
            end
            CALC: begin
                acc_n    = acc_sum;
                mcand_n  = mcand << 1;
                mplier_n = mplier >> 1;
                count_n  = count + CNT_W'(1);
                // P only moves on the final iteration so downstream sees a steady value
                if (count == CNT_W'(N - 1)) begin
                    p_n        = acc_sum;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end
    assign bus.P    = p_reg;
    assign bus.Busy = (state != IDLE);
    assign bus.Done = (state == DONE);
endmodule
